// File: rtl/gol_grid_engine.sv
// -----------------------------------------------------------------------------
// gol_grid_engine
//   ROWS x COLS Game-of-Life array. Every cell is updated in parallel once per
//   generation. The grid is loaded row-serially. Birth/survive rules are
//   programmable. Generations are advanced either by a single-step pulse or by
//   a free-run level. The block reports a generation counter, a registered
//   population count, and stable/extinct status.
//
//   Optional feature macro: GOL_TORUS_EN
//     defined   : toroidal grid (edges wrap around)
//     undefined : dead border (cells beyond the edges count as 0)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   load_start          pulse: begin (or restart) a row-serial load at row 0
//   load_valid/load_row row data for the current row pointer; bit c = column c
//   load_ready          high while in LOAD
//   step_req            pulse: compute one generation
//   run                 level: compute one generation every cycle
//   halt_on_stable      free-run stops advancing once stable is set
//   birth_mask          bit n: dead cell with n live neighbours is born
//   survive_mask        bit n: live cell with n live neighbours survives
//   grid                cell (r,c) at bit r*COLS+c
//   gen_count           generations since last load (saturating)
//   alive_count         popcount of grid (registered alongside grid)
//   step_done           1-cycle pulse in the cycle a new generation appears
//   stable              the last generation produced no change
//   extinct             alive_count == 0
//   o_dbg_state         current FSM state (0 = IDLE, 1 = LOAD)
//
// Handshake: a load row is accepted on any rising edge where the block is in
//   LOAD (load_ready=1) and load_valid=1, unless load_start is also high at
//   that edge; load_start then takes priority and rewinds the row pointer.
// -----------------------------------------------------------------------------
module gol_grid_engine #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_start,
    input  logic                             load_valid,
    input  logic [COLS-1:0]                  load_row,
    output logic                             load_ready,
    input  logic                             step_req,
    input  logic                             run,
    input  logic                             halt_on_stable,
    input  logic [8:0]                       birth_mask,
    input  logic [8:0]                       survive_mask,
    output logic [ROWS*COLS-1:0]             grid,
    output logic [GEN_W-1:0]                 gen_count,
    output logic [$clog2(ROWS*COLS+1)-1:0]   alive_count,
    output logic                             step_done,
    output logic                             stable,
    output logic                             extinct,
    output logic                             o_dbg_state
);

    localparam int N   = ROWS * COLS;
    localparam int AW  = $clog2(N + 1);
    localparam int RPW = $clog2(ROWS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t           r_state, w_state_d;
    logic [RPW-1:0]   r_row_ptr, w_ptr_d;
    logic [N-1:0]     r_grid, w_grid_d, w_next, w_load_grid;
    logic [GEN_W-1:0] r_gen;
    logic [AW-1:0]    r_alive;
    logic             r_step_done, r_stable, r_extinct;
    logic             w_do_step, w_load_done;
    logic [AW-1:0]    w_psum [0:N];

    // Next-generation compute: one neighbour counter and rule lookup per cell.
    // Neighbour indices are elaboration-time constants; in the dead-border build
    // out-of-grid neighbours are forced to 0 instead of wrapping.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int RU = (r == 0)      ? ROWS - 1 : r - 1;
            localparam int RD = (r == ROWS-1) ? 0        : r + 1;
            localparam int CL = (c == 0)      ? COLS - 1 : c - 1;
            localparam int CR = (c == COLS-1) ? 0        : c + 1;
`ifdef GOL_TORUS_EN
            localparam bit VU = 1'b1;
            localparam bit VD = 1'b1;
            localparam bit VL = 1'b1;
            localparam bit VR = 1'b1;
`else
            localparam bit VU = (r != 0);
            localparam bit VD = (r != ROWS-1);
            localparam bit VL = (c != 0);
            localparam bit VR = (c != COLS-1);
`endif
            logic [7:0] w_nb;
            logic [3:0] w_n;
            assign w_nb[0] = (VU && VL) ? r_grid[RU*COLS+CL] : 1'b0;
            assign w_nb[1] =  VU        ? r_grid[RU*COLS+c]  : 1'b0;
            assign w_nb[2] = (VU && VR) ? r_grid[RU*COLS+CR] : 1'b0;
            assign w_nb[3] =  VL        ? r_grid[r*COLS+CL]  : 1'b0;
            assign w_nb[4] =  VR        ? r_grid[r*COLS+CR]  : 1'b0;
            assign w_nb[5] = (VD && VL) ? r_grid[RD*COLS+CL] : 1'b0;
            assign w_nb[6] =  VD        ? r_grid[RD*COLS+c]  : 1'b0;
            assign w_nb[7] = (VD && VR) ? r_grid[RD*COLS+CR] : 1'b0;
            assign w_n = {3'b000, w_nb[0]} + {3'b000, w_nb[1]} + {3'b000, w_nb[2]}
                       + {3'b000, w_nb[3]} + {3'b000, w_nb[4]} + {3'b000, w_nb[5]}
                       + {3'b000, w_nb[6]} + {3'b000, w_nb[7]};
            assign w_next[r*COLS+c] = r_grid[r*COLS+c] ? survive_mask[w_n] : birth_mask[w_n];

            // Grid image with the row at the load pointer replaced by load_row.
            if (c == 0) begin : g_load
                assign w_load_grid[r*COLS +: COLS] =
                    (r_row_ptr == RPW'(r)) ? load_row : r_grid[r*COLS +: COLS];
            end
        end
    end

    // Population count of the value about to be registered into the grid.
    assign w_psum[0] = '0;
    for (genvar i = 0; i < N; i++) begin : g_pop
        assign w_psum[i+1] = w_psum[i] + AW'(w_grid_d[i]);
    end

    always_comb begin
        w_state_d   = r_state;
        w_ptr_d     = r_row_ptr;
        w_grid_d    = r_grid;
        w_do_step   = 1'b0;
        w_load_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_state_d = S_LOAD;
                    w_ptr_d   = '0;
                end else if (step_req || (run && !(halt_on_stable && r_stable))) begin
                    w_do_step = 1'b1;
                    w_grid_d  = w_next;
                end
            end
            S_LOAD: begin
                if (load_start) begin
                    w_ptr_d = '0;
                end else if (load_valid) begin
                    w_grid_d = w_load_grid;
                    if (r_row_ptr == RPW'(ROWS - 1)) begin
                        w_state_d   = S_IDLE;
                        w_ptr_d     = '0;
                        w_load_done = 1'b1;
                    end else begin
                        w_ptr_d = r_row_ptr + RPW'(1);
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_row_ptr   <= '0;
            r_grid      <= '0;
            r_gen       <= '0;
            r_alive     <= '0;
            r_step_done <= 1'b0;
            r_stable    <= 1'b0;
            r_extinct   <= 1'b1;
        end else begin
            r_state     <= w_state_d;
            r_row_ptr   <= w_ptr_d;
            r_grid      <= w_grid_d;
            r_step_done <= w_do_step;
            if (w_do_step) begin
                if (r_gen != '1) begin
                    r_gen <= r_gen + GEN_W'(1);
                end
                r_stable  <= (w_next == r_grid);
                r_alive   <= w_psum[N];
                r_extinct <= (w_psum[N] == '0);
            end else if (w_load_done) begin
                r_gen     <= '0;
                r_stable  <= 1'b0;
                r_alive   <= w_psum[N];
                r_extinct <= (w_psum[N] == '0);
            end
        end
    end

    assign load_ready  = (r_state == S_LOAD);
    assign grid        = r_grid;
    assign gen_count   = r_gen;
    assign alive_count = r_alive;
    assign step_done   = r_step_done;
    assign stable      = r_stable;
    assign extinct     = r_extinct;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gol_grid_engine.sv
module tb_gol_grid_engine;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int N     = ROWS * COLS;
  localparam int GEN_W = 16;
  localparam int AW    = $clog2(N + 1);

  // Patterns: cell (r,c) at bit r*8+c
  localparam logic [N-1:0] BLINK_H = 64'h0000_0000_000E_0000; // row2 cols1-3
  localparam logic [N-1:0] BLINK_V = 64'h0000_0000_0404_0400; // col2 rows1-3
  localparam logic [N-1:0] BLOCK   = 64'h0000_0000_0006_0600; // rows1-2 cols1-2
  localparam logic [N-1:0] GLIDER  = 64'h0000_0000_0007_0402; // (0,1)(1,2)(2,0..2)
  localparam logic [N-1:0] CORNER  = 64'hC0C0_0000_0000_0000; // rows6-7 cols6-7
  localparam logic [N-1:0] SINGLE  = 64'h0000_0000_1000_0000; // (3,4)
  localparam logic [8:0]   CONWAY_B = 9'h008;
  localparam logic [8:0]   CONWAY_S = 9'h00C;

  logic             clk;
  logic             rst_n;
  logic             load_start;
  logic             load_valid;
  logic [COLS-1:0]  load_row;
  logic             load_ready;
  logic             step_req;
  logic             run;
  logic             halt_on_stable;
  logic [8:0]       birth_mask;
  logic [8:0]       survive_mask;
  logic [N-1:0]     grid;
  logic [GEN_W-1:0] gen_count;
  logic [AW-1:0]    alive_count;
  logic             step_done;
  logic             stable;
  logic             extinct;
  logic             dbg_state;

  int n_checks;
  int n_errors;

  gol_grid_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_start     (load_start),
    .load_valid     (load_valid),
    .load_row       (load_row),
    .load_ready     (load_ready),
    .step_req       (step_req),
    .run            (run),
    .halt_on_stable (halt_on_stable),
    .birth_mask     (birth_mask),
    .survive_mask   (survive_mask),
    .grid           (grid),
    .gen_count      (gen_count),
    .alive_count    (alive_count),
    .step_done      (step_done),
    .stable         (stable),
    .extinct        (extinct),
    .o_dbg_state    (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish before 100us");
    $fatal(1, "watchdog expired");
  end

  // checking
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_grid(input logic [N-1:0] g);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      load_valid = 1'b1;
      load_row   = COLS'(g >> (r * COLS));
      tick();
    end
    load_valid = 1'b0;
    load_row   = '0;
  endtask

  task automatic step();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    load_start     = 1'b0;
    load_valid     = 1'b0;
    load_row       = '0;
    step_req       = 1'b0;
    run            = 1'b0;
    halt_on_stable = 1'b0;
    birth_mask     = CONWAY_B;
    survive_mask   = CONWAY_S;

    // reset state
    tick();
    tick();
    check("rst_grid",      64'(grid), 64'(0));
    check("rst_gen",       64'(gen_count), 64'(0));
    check("rst_alive",     64'(alive_count), 64'(0));
    check("rst_extinct",   64'(extinct), 64'(1));
    check("rst_ready",     64'(load_ready), 64'(0));
    check("rst_step_done", 64'(step_done), 64'(0));
    check("rst_stable",    64'(stable), 64'(0));
    check("rst_state",     64'(dbg_state), 64'(0));
    rst_n = 1'b1;
    tick();

    // blinker
    load_grid(BLINK_H);
    check("blk_load_grid",  64'(grid), 64'(BLINK_H));
    check("blk_load_alive", 64'(alive_count), 64'(3));
    check("blk_load_ext",   64'(extinct), 64'(0));
    check("blk_load_gen",   64'(gen_count), 64'(0));
    check("blk_load_done",  64'(step_done), 64'(0));
    step();
    check("blk1_grid",   64'(grid), 64'(BLINK_V));
    check("blk1_gen",    64'(gen_count), 64'(1));
    check("blk1_alive",  64'(alive_count), 64'(3));
    check("blk1_stable", 64'(stable), 64'(0));
    check("blk1_done",   64'(step_done), 64'(1));
    tick();
    check("blk1_done_low", 64'(step_done), 64'(0));
    step();
    check("blk2_grid", 64'(grid), 64'(BLINK_H));
    check("blk2_gen",  64'(gen_count), 64'(2));

    // still life under free-run with halt_on_stable
    load_grid(BLOCK);
    halt_on_stable = 1'b1;
    run = 1'b1;
    repeat (6) tick();
    check("still_stable", 64'(stable), 64'(1));
    check("still_gen",    64'(gen_count), 64'(1));
    check("still_grid",   64'(grid), 64'(BLOCK));
    check("still_alive",  64'(alive_count), 64'(4));
    run = 1'b0;
    halt_on_stable = 1'b0;

    // programmable rules: lone cell survives with 0 neighbours
    birth_mask   = 9'h000;
    survive_mask = 9'h001;
    load_grid(SINGLE);
    step();
    check("single_grid",   64'(grid), 64'(SINGLE));
    check("single_alive",  64'(alive_count), 64'(1));
    check("single_stable", 64'(stable), 64'(1));
    birth_mask   = CONWAY_B;
    survive_mask = CONWAY_S;
    step();
    check("single_dies",  64'(grid), 64'(0));
    check("single_ext",   64'(extinct), 64'(1));
    check("single_alive0", 64'(alive_count), 64'(0));
    check("single_gen",   64'(gen_count), 64'(2));

    // glider, 32 generations
    load_grid(GLIDER);
    for (int g = 1; g <= 32; g++) begin
      step();
`ifdef GOL_TORUS_EN
      if (g % 4 == 0) check("glider_alive", 64'(alive_count), 64'(5));
`endif
    end
`ifdef GOL_TORUS_EN
    check("glider_wrap_grid", 64'(grid), 64'(GLIDER));
`else
    check("glider_block_grid", 64'(grid), 64'(CORNER));
    check("glider_alive",      64'(alive_count), 64'(4));
    check("glider_stable",     64'(stable), 64'(1));
`endif
    check("glider_gen", 64'(gen_count), 64'(32));

    // load_start while running
    load_grid(BLINK_H);
    run = 1'b1;
    repeat (3) tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("lrun_gen_hold", 64'(gen_count), 64'(3));
    check("lrun_ready",    64'(load_ready), 64'(1));
    check("lrun_done_low", 64'(step_done), 64'(0));
    check("lrun_state",    64'(dbg_state), 64'(1));
    for (int r = 0; r < ROWS; r++) begin
      load_valid = 1'b1;
      load_row   = COLS'(BLOCK >> (r * COLS));
      tick();
      if (r == 3) check("lrun_gen_mid", 64'(gen_count), 64'(3));
    end
    load_valid = 1'b0;
    check("lrun_gen0",   64'(gen_count), 64'(0));
    check("lrun_grid",   64'(grid), 64'(BLOCK));
    check("lrun_idle",   64'(load_ready), 64'(0));
    check("lrun_stable", 64'(stable), 64'(0));
    check("lrun_alive",  64'(alive_count), 64'(4));
    run = 1'b0;
    tick();

    // reset during LOAD row 3
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      load_valid = 1'b1;
      load_row   = 8'hFF;
      tick();
    end
    load_row = 8'hFF;
    #2;
    rst_n = 1'b0;
    #1;
    check("rld_grid",    64'(grid), 64'(0));
    check("rld_state",   64'(dbg_state), 64'(0));
    check("rld_ready",   64'(load_ready), 64'(0));
    check("rld_gen",     64'(gen_count), 64'(0));
    check("rld_extinct", 64'(extinct), 64'(1));
    tick();
    rst_n = 1'b1;
    tick();
    check("rld_after_ready", 64'(load_ready), 64'(0));
    check("rld_after_grid",  64'(grid), 64'(0));
    load_valid = 1'b0;
    load_row   = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
